range_buf_arbiter: RTL and testbench
====================================

RANGE_BUF_ARBITER -- requirements
Module: range_buf_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, number of range entries (power of two, 2..16).
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk_i  in  1  clock, rising-edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  synchronous request to clear all entries.
REQ-006 heap_valid_i / heap_ready_o  in/out  1/1  heap-overflow writer handshake.
REQ-007 heap_start_i, heap_end_i  in  AW each  heap range, inclusive bounds.
REQ-008 dlk_valid_i / dlk_ready_o  in/out  1/1  dataleak writer handshake.
REQ-009 dlk_start_i, dlk_end_i  in  AW each  dataleak range, inclusive bounds.
REQ-010 lookup_valid_i  in  1  address query strobe.
REQ-011 lookup_addr_i  in  AW  query address.
REQ-012 hit_valid_o  out  1  lookup result valid.
REQ-013 hit_o  out  1  queried address inside a valid entry.
REQ-014 hit_idx_o  out  $clog2(DEPTH)  lowest matching entry index.
REQ-015 count_o  out  $clog2(DEPTH)+1  number of valid entries.
REQ-016 err_o  out  1  one-cycle pulse: accepted range with start > end, dropped.
REQ-017 busy_o  out  1  high while in FLUSH state.

Function
REQ-018 FSM states RUN and FLUSH; reset enters RUN.
REQ-019 RUN -> FLUSH when flush_i=1; FLUSH clears one entry valid bit per cycle, index 0..DEPTH-1, then returns to RUN (exactly DEPTH cycles in FLUSH).
REQ-020 flush_i while already in FLUSH restarts the clear index at 0.
REQ-021 In FLUSH: heap_ready_o=dlk_ready_o=0, hit_o=0, count_o forced to 0 on entry.
REQ-022 In RUN both ready outputs are 1 for the arbitration winner only; at most one write accepted per cycle.
REQ-023 Arbitration round-robin: single requester always wins; on contention the writer not granted last wins; grant pointer resets to heap.
REQ-024 Handshake: transfer when valid&ready; a writer holding valid keeps its data stable until accepted.
REQ-025 Accepted range with start <= end written at head pointer, entry marked valid, head incremented modulo DEPTH.
REQ-026 Full (count_o=DEPTH): write overwrites oldest entry at head, count_o saturates at DEPTH.
REQ-027 Merge: if accepted start == end of most recently written valid entry + 1, that entry's end is updated instead; head and count unchanged.
REQ-028 Accepted range with start > end: no state change, err_o=1 next cycle.
REQ-029 Lookup latency 1 cycle: hit_valid_o, hit_o, hit_idx_o registered from lookup_valid_i of previous cycle.
REQ-030 Match rule: entry valid and start <= addr <= end, unsigned compare, full AW.
REQ-031 Lookup and write in same cycle: lookup evaluates pre-write contents.
REQ-032 hit_o=0 implies hit_idx_o=0; hit_valid_o=0 implies hit_o=0.
REQ-033 flush_i and write valid in same RUN cycle: flush wins, write not accepted (ready=0).

Reset
REQ-034 Reset: all valid bits 0, head 0, count_o 0, state RUN, grant pointer heap, hit_valid_o/hit_o/hit_idx_o/err_o/busy_o 0, ready outputs 0 during reset.
REQ-035 Reset asserted mid-FLUSH or mid-handshake aborts immediately; no partial write survives.

Structure
REQ-036 Range entry typedef (start, end, valid) and FSM state enum in shared package insa_pkg.
REQ-037 One sub-module: range_rr_arb (two-input round-robin arbiter with grant-pointer register).
REQ-038 Entry storage in flops; no RAM macro; combinational compare across all entries, priority-encoded to lowest index.

Verification
REQ-039 Heap write [0x1000,0x1020], then lookup 0x1020 -> next cycle hit_valid_o=1, hit_o=1, hit_idx_o=0; lookup 0x1021 -> hit_o=0.
REQ-040 Both writers valid continuously 4 cycles from reset -> grants heap, dlk, heap, dlk; count_o=4.
REQ-041 DEPTH+1 disjoint writes -> count_o=DEPTH, first range no longer hits, last range hits at index 0.
REQ-042 Write [0x2000,0x200F] then [0x2010,0x201F] -> count_o=1, lookup 0x201F hits index 0.
REQ-043 Write [0x30,0x10] -> err_o pulse one cycle, count_o unchanged.
REQ-044 4 entries valid, flush_i one cycle -> busy_o high exactly DEPTH cycles, ready low, all lookups miss, count_o=0 afterwards; reset asserted at flush cycle 3 -> RUN, count_o=0 immediately.

Source files
------------

// File: rtl/insa_pkg.sv
// Shared types for the range buffer: entry record, FSM state, and the range-match helper.
package insa_pkg;

    localparam int unsigned ADDR_MAX_W = 64;

    typedef logic [ADDR_MAX_W-1:0] addr_t;

    // Addresses are zero-extended to ADDR_MAX_W so end+1 never wraps inside AW.
    typedef struct packed {
        addr_t start_addr;
        addr_t end_addr;
        logic  valid;
    } range_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic entry_hit(range_entry_t e, addr_t a);
        return e.valid && (a >= e.start_addr) && (a <= e.end_addr);
    endfunction

endpackage

// File: rtl/range_rr_arb.sv
// Two-input round-robin arbiter; input 0 (heap) is preferred out of reset.
module range_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c
);

    // prio_q=1 means input 1 wins the next contention.
    logic prio_q;

    always_comb begin
        gnt_c = 2'b00;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || !prio_q)) begin
                gnt_c = 2'b01;
            end else if (req_i[1]) begin
                gnt_c = 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (gnt_c[0]) begin
            prio_q <= 1'b1;
        end else if (gnt_c[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/range_buf_arbiter.sv
// Circular buffer of address ranges fed by two arbitrated writers, with
// single-cycle lookup, adjacent-range merging and a sequential flush.
module range_buf_arbiter
    import insa_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     heap_valid_i,
    output logic                     heap_ready_o,
    input  logic [AW-1:0]            heap_start_i,
    input  logic [AW-1:0]            heap_end_i,
    input  logic                     dlk_valid_i,
    output logic                     dlk_ready_o,
    input  logic [AW-1:0]            dlk_start_i,
    input  logic [AW-1:0]            dlk_end_i,
    input  logic                     lookup_valid_i,
    input  logic [AW-1:0]            lookup_addr_i,
    output logic                     hit_valid_o,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] hit_idx_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    state_e        state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;

    range_entry_t  entries_q [DEPTH];
    logic [IW-1:0] head_q;
    logic [CW-1:0] count_q;

    logic          err_q, busy_q, hit_valid_q, hit_q;
    logic [IW-1:0] hit_idx_q;

    logic          arb_en;
    logic [1:0]    gnt;
    logic          wr_acc, wr_ok, wr_merge;
    addr_t         wr_start, wr_end, lk_addr;
    logic [IW-1:0] last_idx, match_idx;
    logic          any_match;

    // Writes are only offered in RUN, outside reset, and never alongside a flush request.
    assign arb_en = rst_ni && (state_q == ST_RUN) && !flush_i;

    range_rr_arb u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (arb_en),
        .req_i  ({dlk_valid_i, heap_valid_i}),
        .gnt_c  (gnt)
    );

    assign heap_ready_o = gnt[0];
    assign dlk_ready_o  = gnt[1];

    // Write-path decode: winner data, legality, merge into the last-written entry.
    always_comb begin
        wr_acc   = |gnt;
        wr_start = gnt[1] ? addr_t'(dlk_start_i) : addr_t'(heap_start_i);
        wr_end   = gnt[1] ? addr_t'(dlk_end_i)   : addr_t'(heap_end_i);
        last_idx = head_q - IW'(1);
        wr_ok    = wr_acc && (wr_start <= wr_end);
        wr_merge = wr_ok && (count_q != '0) && entries_q[last_idx].valid &&
                   (wr_start == entries_q[last_idx].end_addr + addr_t'(1));
    end

    // Lowest-index match over the pre-write contents.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        lk_addr   = addr_t'(lookup_addr_i);
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entry_hit(entries_q[i], lk_addr)) begin
                any_match = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d   = ST_FLUSH;
                    clr_idx_d = '0;
                end
            end
            ST_FLUSH: begin
                clr_idx_d = clr_idx_q + IW'(1);
                if (flush_i) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Entry storage; flush entry also rewinds head so the buffer restarts at index 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            count_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            entries_q[clr_idx_q].valid <= 1'b0;
        end else if (flush_i) begin
            head_q  <= '0;
            count_q <= '0;
        end else if (wr_merge) begin
            entries_q[last_idx].end_addr <= wr_end;
        end else if (wr_ok) begin
            entries_q[head_q] <= '{start_addr: wr_start, end_addr: wr_end, valid: 1'b1};
            head_q            <= head_q + IW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            err_q       <= wr_acc && (wr_start > wr_end);
            busy_q      <= (state_d == ST_FLUSH);
            hit_valid_q <= lookup_valid_i;
            hit_q       <= lookup_valid_i && (state_q == ST_RUN) && any_match;
            hit_idx_q   <= (lookup_valid_i && (state_q == ST_RUN) && any_match) ? match_idx : '0;
        end
    end

    assign hit_valid_o = hit_valid_q;
    assign hit_o       = hit_q;
    assign hit_idx_o   = hit_idx_q;
    assign count_o     = count_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_range_buf_arbiter.sv
// Self-checking bench for range_buf_arbiter: directed vector table, corner
// sequences for flush/reset/wrap, and random traffic against a reference model.
module tb_range_buf_arbiter;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int          NV    = 23;

    logic          clk_i;
    logic          rst_ni;
    logic          flush_i;
    logic          heap_valid_i, heap_ready_o;
    logic [AW-1:0] heap_start_i, heap_end_i;
    logic          dlk_valid_i, dlk_ready_o;
    logic [AW-1:0] dlk_start_i, dlk_end_i;
    logic          lookup_valid_i;
    logic [AW-1:0] lookup_addr_i;
    logic          hit_valid_o, hit_o;
    logic [IW-1:0] hit_idx_o;
    logic [IW:0]   count_o;
    logic          err_o, busy_o;

    range_buf_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .heap_valid_i   (heap_valid_i),
        .heap_ready_o   (heap_ready_o),
        .heap_start_i   (heap_start_i),
        .heap_end_i     (heap_end_i),
        .dlk_valid_i    (dlk_valid_i),
        .dlk_ready_o    (dlk_ready_o),
        .dlk_start_i    (dlk_start_i),
        .dlk_end_i      (dlk_end_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_addr_i  (lookup_addr_i),
        .hit_valid_o    (hit_valid_o),
        .hit_o          (hit_o),
        .hit_idx_o      (hit_idx_o),
        .count_o        (count_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i        = 1'b0;
        heap_valid_i   = 1'b0;
        heap_start_i   = '0;
        heap_end_i     = '0;
        dlk_valid_i    = 1'b0;
        dlk_start_i    = '0;
        dlk_end_i      = '0;
        lookup_valid_i = 1'b0;
        lookup_addr_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            rst, flush, hv, dv, lv;
        logic [AW-1:0] hs, he, ds, de, la;
        bit            e_hr, e_dr, e_hitv, e_hit, e_err;
        int            e_idx, e_cnt;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(int rst, int fl, int hv, int hs, int he, int dv, int ds, int de,
                                int lv, int la, int hr, int dr, int hitv, int hit, int idx,
                                int cnt, int err);
        vec_t v;
        v.rst = (rst != 0); v.flush = (fl != 0);
        v.hv = (hv != 0); v.hs = AW'(hs); v.he = AW'(he);
        v.dv = (dv != 0); v.ds = AW'(ds); v.de = AW'(de);
        v.lv = (lv != 0); v.la = AW'(la);
        v.e_hr = (hr != 0); v.e_dr = (dr != 0);
        v.e_hitv = (hitv != 0); v.e_hit = (hit != 0); v.e_idx = idx;
        v.e_cnt = cnt; v.e_err = (err != 0);
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int n);
        rst_ni         = !v.rst;
        flush_i        = v.flush;
        heap_valid_i   = v.hv; heap_start_i = v.hs; heap_end_i = v.he;
        dlk_valid_i    = v.dv; dlk_start_i  = v.ds; dlk_end_i  = v.de;
        lookup_valid_i = v.lv; lookup_addr_i = v.la;
        #1;
        chk($sformatf("v%0d heap_ready", n), 64'(heap_ready_o), 64'(v.e_hr));
        chk($sformatf("v%0d dlk_ready", n), 64'(dlk_ready_o), 64'(v.e_dr));
        tick();
        chk($sformatf("v%0d hit_valid", n), 64'(hit_valid_o), 64'(v.e_hitv));
        chk($sformatf("v%0d hit", n), 64'(hit_o), 64'(v.e_hit));
        chk($sformatf("v%0d hit_idx", n), 64'(hit_idx_o), 64'(v.e_idx));
        chk($sformatf("v%0d count", n), 64'(count_o), 64'(v.e_cnt));
        chk($sformatf("v%0d err", n), 64'(err_o), 64'(v.e_err));
        chk($sformatf("v%0d busy", n), 64'(busy_o), 64'd0);
        rst_ni = 1'b1;
    endtask

    // ---------------- hand-written corner sequences ----------------
    task automatic seq_flush();
        idle_inputs();
        flush_i = 1'b1; heap_valid_i = 1'b1; heap_start_i = 'h700; heap_end_i = 'h70F;
        #1;
        chk("flush_wins_ready", 64'(heap_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            chk($sformatf("flush%0d busy", k), 64'(busy_o), 64'd1);
            chk($sformatf("flush%0d count", k), 64'(count_o), 64'd0);
            lookup_valid_i = 1'b1; lookup_addr_i = 'h400;
            #1;
            chk($sformatf("flush%0d heap_ready", k), 64'(heap_ready_o), 64'd0);
            tick();
            chk($sformatf("flush%0d hit", k), 64'(hit_o), 64'd0);
            chk($sformatf("flush%0d hit_valid", k), 64'(hit_valid_o), 64'd1);
        end
        heap_valid_i = 1'b0;
        chk("flush_end busy", 64'(busy_o), 64'd0);
        lookup_valid_i = 1'b1; lookup_addr_i = 'h400;
        tick();
        chk("flush_after hit", 64'(hit_o), 64'd0);
        chk("flush_after count", 64'(count_o), 64'd0);
        idle_inputs();
    endtask

    task automatic seq_flush_restart();
        int busy_n;
        idle_inputs();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        busy_n  = 0;
        for (int c = 0; c < 40 && busy_o; c++) begin
            busy_n++;
            flush_i = (busy_n == 2);
            tick();
        end
        flush_i = 1'b0;
        chk("flush_restart_len", 64'(busy_n), 64'(DEPTH + 2));
    endtask

    task automatic seq_reset_mid_flush();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            heap_valid_i = 1'b1;
            heap_start_i = AW'('h800 + 'h20 * i);
            heap_end_i   = AW'('h80F + 'h20 * i);
            tick();
        end
        heap_valid_i = 1'b0;
        chk("rmf count4", 64'(count_o), 64'd4);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        chk("rmf busy_before", 64'(busy_o), 64'd1);
        rst_ni = 1'b0; heap_valid_i = 1'b1; heap_start_i = 'h900; heap_end_i = 'h90F;
        #1;
        chk("rmf busy_reset", 64'(busy_o), 64'd0);
        chk("rmf count_reset", 64'(count_o), 64'd0);
        chk("rmf ready_reset", 64'(heap_ready_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rmf ready_run", 64'(heap_ready_o), 64'd1);
        heap_valid_i = 1'b0;
        lookup_valid_i = 1'b1; lookup_addr_i = 'h800;
        tick();
        chk("rmf hit", 64'(hit_o), 64'd0);
        chk("rmf count_after", 64'(count_o), 64'd0);
        chk("rmf busy_after", 64'(busy_o), 64'd0);
        idle_inputs();
    endtask

    task automatic seq_wrap();
        do_reset();
        for (int k = 0; k <= int'(DEPTH); k++) begin
            heap_valid_i = 1'b1;
            heap_start_i = AW'('h10000 + k * 'h100);
            heap_end_i   = AW'('h1000F + k * 'h100);
            tick();
            chk($sformatf("wrap%0d count", k), 64'(count_o),
                64'((k + 1 < int'(DEPTH)) ? k + 1 : int'(DEPTH)));
        end
        heap_valid_i = 1'b0;
        lookup_valid_i = 1'b1; lookup_addr_i = 'h10000;
        tick();
        chk("wrap first_gone", 64'(hit_o), 64'd0);
        lookup_addr_i = AW'('h10000 + DEPTH * 'h100);
        tick();
        chk("wrap last hit", 64'(hit_o), 64'd1);
        chk("wrap last idx", 64'(hit_idx_o), 64'd0);
        lookup_addr_i = 'h1010A;
        tick();
        chk("wrap second idx", 64'(hit_idx_o), 64'd1);
        chk("wrap second hit", 64'(hit_o), 64'd1);
        idle_inputs();
    endtask

    // ---------------- reference model ----------------
    bit              m_valid [DEPTH];
    longint unsigned m_s [DEPTH];
    longint unsigned m_e [DEPTH];
    int              m_head, m_last, m_left, m_lastwin;

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_valid[i] = 1'b0; m_s[i] = 0; m_e[i] = 0;
        end
        m_head = 0; m_last = -1; m_left = 0; m_lastwin = 1;
    endfunction

    function automatic int m_pop();
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic gen_range(output logic [AW-1:0] s, output logic [AW-1:0] e);
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) begin
            s = AW'($urandom_range(40, 300));
            e = s - AW'($urandom_range(1, 30));
        end else if (r <= 2 && m_last >= 0) begin
            s = AW'(m_e[m_last] + 64'd1);
            e = s + AW'($urandom_range(0, 15));
        end else begin
            s = AW'($urandom_range(0, 300));
            e = s + AW'($urandom_range(0, 15));
        end
    endtask

    task automatic run_random(input int cycles);
        bit              h_pend, d_pend, busy, e_hit, e_err;
        int              win, e_idx;
        longint unsigned ws, we, la;
        do_reset();
        model_reset();
        h_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (!h_pend) begin
                heap_valid_i = ($urandom_range(0, 2) != 0);
                gen_range(heap_start_i, heap_end_i);
            end
            if (!d_pend) begin
                dlk_valid_i = ($urandom_range(0, 2) != 0);
                gen_range(dlk_start_i, dlk_end_i);
            end
            flush_i        = ($urandom_range(0, 59) == 0);
            lookup_valid_i = $urandom_range(0, 1) != 0;
            lookup_addr_i  = $urandom_range(0, 330);
            #1;
            busy = (m_left > 0);
            win  = -1;
            if (!busy && !flush_i) begin
                if (heap_valid_i && dlk_valid_i) win = 1 - m_lastwin;
                else if (heap_valid_i)           win = 0;
                else if (dlk_valid_i)            win = 1;
            end
            chk($sformatf("rnd%0d heap_ready", c), 64'(heap_ready_o), 64'(win == 0));
            chk($sformatf("rnd%0d dlk_ready", c), 64'(dlk_ready_o), 64'(win == 1));

            e_hit = 1'b0; e_idx = 0; e_err = 1'b0;
            la = 64'(lookup_addr_i);
            if (lookup_valid_i && !busy) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (!e_hit && m_valid[i] && la >= m_s[i] && la <= m_e[i]) begin
                        e_hit = 1'b1; e_idx = i;
                    end
                end
            end

            if (busy) begin
                m_valid[int'(DEPTH) - m_left] = 1'b0;
                m_left = flush_i ? int'(DEPTH) : m_left - 1;
            end else if (flush_i) begin
                m_left = int'(DEPTH); m_head = 0; m_last = -1;
            end else if (win >= 0) begin
                ws = (win == 0) ? 64'(heap_start_i) : 64'(dlk_start_i);
                we = (win == 0) ? 64'(heap_end_i)   : 64'(dlk_end_i);
                m_lastwin = win;
                if (ws > we) begin
                    e_err = 1'b1;
                end else if (m_last >= 0 && m_valid[m_last] && ws == m_e[m_last] + 1) begin
                    m_e[m_last] = we;
                end else begin
                    m_s[m_head] = ws; m_e[m_head] = we; m_valid[m_head] = 1'b1;
                    m_last = m_head;
                    m_head = (m_head + 1) % int'(DEPTH);
                end
            end
            h_pend = heap_valid_i && (win != 0);
            d_pend = dlk_valid_i && (win != 1);

            tick();
            chk($sformatf("rnd%0d hit_valid", c), 64'(hit_valid_o), 64'(lookup_valid_i));
            chk($sformatf("rnd%0d hit", c), 64'(hit_o), 64'(e_hit));
            chk($sformatf("rnd%0d hit_idx", c), 64'(hit_idx_o), 64'(e_idx));
            chk($sformatf("rnd%0d err", c), 64'(err_o), 64'(e_err));
            chk($sformatf("rnd%0d busy", c), 64'(busy_o), 64'(m_left > 0));
            chk($sformatf("rnd%0d count", c), 64'(count_o), 64'((m_left > 0) ? 0 : m_pop()));
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit after %0d checks", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        //            rst fl hv hs      he      dv ds      de      lv la      hr dr hv hit idx cnt err
        tbl[0]  = mk(1, 0, 1, 'h1000, 'h1020, 0, 0,      0,      0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 'h1000, 'h1020, 0, 0,      0,      0, 0,      1, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h1020, 0, 0, 1, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h1021, 0, 0, 1, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h1000, 0, 0, 1, 1, 0, 1, 0);
        tbl[5]  = mk(1, 0, 0, 0,      0,      0, 0,      0,      0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 'h2000, 'h200F, 0, 0,      0,      0, 0,      1, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0,      0,      1, 'h2010, 'h201F, 0, 0,      0, 1, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h201F, 0, 0, 1, 1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h2020, 0, 0, 1, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 1, 'h30,   'h10,   0, 0,      0,      0, 0,      1, 0, 0, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0,      0,      0, 0,      0,      0, 0,      0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h2000, 0, 0, 1, 1, 0, 1, 0);
        tbl[13] = mk(1, 0, 0, 0,      0,      0, 0,      0,      0, 0,      0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 'h100,  'h10F,  1, 'h300,  'h30F,  0, 0,      1, 0, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 1, 'h200,  'h20F,  1, 'h300,  'h30F,  0, 0,      0, 1, 0, 0, 0, 2, 0);
        tbl[16] = mk(0, 0, 1, 'h200,  'h20F,  1, 'h400,  'h40F,  0, 0,      1, 0, 0, 0, 0, 3, 0);
        tbl[17] = mk(0, 0, 1, 'h500,  'h50F,  1, 'h400,  'h40F,  0, 0,      0, 1, 0, 0, 0, 4, 0);
        tbl[18] = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h400,  0, 0, 1, 1, 3, 4, 0);
        tbl[19] = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h205,  0, 0, 1, 1, 2, 4, 0);
        tbl[20] = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h30F,  0, 0, 1, 1, 1, 4, 0);
        tbl[21] = mk(0, 0, 1, 'h600,  'h60F,  0, 0,      0,      1, 'h600,  1, 0, 1, 0, 0, 5, 0);
        tbl[22] = mk(0, 0, 0, 0,      0,      0, 0,      0,      1, 'h600,  0, 0, 1, 1, 4, 5, 0);

        for (int i = 0; i < NV; i++) apply_vec(tbl[i], i);
        idle_inputs();

        seq_flush();
        seq_flush_restart();
        seq_reset_mid_flush();
        seq_wrap();
        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
